// File: rtl/uart_tx_sequencer_pkg.sv
// Shared constants and types for the console UART transmit sequencer.
// Holds the UART register map, AXI response codes and the sequencer state encoding.
package uart_tx_sequencer_pkg;

    localparam logic [31:0] UART_THR_ADDR   = 32'h0000_0004;
    localparam logic [31:0] UART_STAT_ADDR  = 32'h0000_0014;
    localparam int unsigned UART_TX_RDY_BIT = 2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPollAr,
        StPollR,
        StGap,
        StWr,
        StResp
    } seq_state_e;

endpackage

// File: rtl/uart_tx_sequencer_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty detection.
// The head entry is presented combinationally and is only consumed on pop.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// AXI-Lite master sharing the console UART between two byte requesters.
// Round-robin arbiter feeds a FIFO; an FSM writes each byte to THR, optionally polling TX-ready.
module uart_tx_sequencer
    import uart_tx_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter logic [31:0] THR_ADDR   = UART_THR_ADDR,
    parameter logic [31:0] STAT_ADDR  = UART_STAT_ADDR,
    parameter int unsigned TX_RDY_BIT = UART_TX_RDY_BIT,
    parameter bit          POLL_EN    = 1'b1,
    parameter int unsigned POLL_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [31:0] aw_addr,
    output logic [2:0]  aw_prot,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [3:0]  w_strb,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [1:0]  b_resp,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [31:0] ar_addr,
    output logic [2:0]  ar_prot,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    output logic        busy,
    output logic [15:0] bytes_sent,
    output logic        bresp_err
);

    localparam logic [15:0] GapLast = 16'(POLL_GAP - 1);

    seq_state_e  state_q;
    logic        rr_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic [15:0] gap_cnt_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  push_data;
    logic        grant0;
    logic        grant1;
    logic        aw_fire;
    logic        w_fire;
    logic        aw_fin;
    logic        w_fin;
    logic        tx_ready;
    logic        unused_r_data;

    // rr_q == 0 favours requester 0 when both are valid.
    assign grant0     = req0_valid && (!req1_valid || !rr_q);
    assign grant1     = req1_valid && (!req0_valid || rr_q);
    assign req0_ready = grant0 && !fifo_full;
    assign req1_ready = grant1 && !fifo_full;
    assign fifo_push  = req0_ready || req1_ready;
    assign push_data  = req0_ready ? req0_data : req1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else if (req0_valid && req1_valid && !fifo_full) begin
            rr_q <= !rr_q;
        end
    end

    // Head is popped only once the write response arrives, so no byte is lost on a slow UART.
    assign fifo_pop = (state_q == StResp) && b_valid;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign aw_addr = THR_ADDR;
    assign aw_prot = 3'b000;
    assign w_data  = {24'h0, fifo_head};
    assign w_strb  = 4'b0001;
    assign ar_addr = STAT_ADDR;
    assign ar_prot = 3'b000;
    assign busy    = !fifo_empty || (state_q != StIdle);

    assign aw_fire  = aw_valid && aw_ready;
    assign w_fire   = w_valid && w_ready;
    assign aw_fin   = aw_done_q || aw_fire;
    assign w_fin    = w_done_q || w_fire;
    // An errored status read is treated as "not ready" and retried after the gap.
    assign tx_ready = r_data[TX_RDY_BIT] && (r_resp == AXI_RESP_OKAY);
    assign unused_r_data = ^r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            b_ready    <= 1'b0;
            ar_valid   <= 1'b0;
            r_ready    <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            gap_cnt_q  <= '0;
            bytes_sent <= '0;
            bresp_err  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        if (POLL_EN) begin
                            state_q  <= StPollAr;
                            ar_valid <= 1'b1;
                        end else begin
                            state_q  <= StWr;
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                        end
                    end
                end
                StPollAr: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state_q  <= StPollR;
                    end
                end
                StPollR: begin
                    if (r_valid) begin
                        r_ready <= 1'b0;
                        if (tx_ready) begin
                            state_q  <= StWr;
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                        end else begin
                            state_q   <= StGap;
                            gap_cnt_q <= '0;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q  <= StPollAr;
                        ar_valid <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                StWr: begin
                    if (aw_fire) begin
                        aw_valid  <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_fire) begin
                        w_valid  <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        b_ready   <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (b_valid) begin
                        b_ready    <= 1'b0;
                        bytes_sent <= bytes_sent + 16'd1;
                        if (b_resp != AXI_RESP_OKAY) bresp_err <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
